hash_cmd_issuer: RTL

Request-side initiator for the hash table stream wrapper. It accepts host commands (read, write, delete), buffers them in a small FIFO and issues them on the table's input stream with a limit on requests in flight. It also takes the table's output stream, returns each response to the host through a one-entry output register, and tracks the outstanding count. It sits between the host/DMA stream and the table wrapper, and owns both stream directions of the table.

---
 rtl/hash_cmd_issuer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hash_cmd_issuer.sv
// hash_cmd_issuer: host command FIFO and credit-limited issue onto the hash
// table input stream, plus a one-entry response register back to the host.
module hash_cmd_issuer #(
  parameter  int unsigned KEY_WIDTH       = 32,
  parameter  int unsigned DATA_WIDTH      = 30,
  parameter  int unsigned FIFO_DEPTH      = 4,
  parameter  int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned W               = 2 + KEY_WIDTH + DATA_WIDTH,
  localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  // host command stream
  input  logic [W-1:0]  cmd_data_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  // table input stream
  output logic [W-1:0]  tbl_data_o,
  output logic          tbl_valid_o,
  input  logic          tbl_ready_i,
  output logic          tbl_keep_o,
  output logic          tbl_last_o,
  // table output stream
  input  logic [W-1:0]  rsp_data_i,
  input  logic          rsp_valid_i,
  output logic          rsp_ready_o,
  // host response stream
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  // status
  output logic [OW-1:0] outstanding_o,
  output logic [15:0]   nop_cnt_o,
  output logic          underflow_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OP_MSB = W - 1;
  localparam int unsigned OP_LSB = W - 2;

  // command FIFO state
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  // credit, response register and status state
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   nop_cnt_q, nop_cnt_d;
  logic          underflow_q, underflow_d;

  // handshake qualifiers
  logic [1:0] cmd_op;
  logic       cmd_acc;
  logic       push;
  logic       nop_acc;
  logic       fifo_empty;
  logic       credit_ok;
  logic       issue;
  logic       rsp_hs;

  // host-side readiness depends only on the registered full flag
  assign cmd_ready_o = ~full_q & ~reset;
  assign cmd_op      = cmd_data_i[OP_MSB:OP_LSB];
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign push        = cmd_acc & (cmd_op != 2'b00);
  assign nop_acc     = cmd_acc & (cmd_op == 2'b00);

  // head of FIFO is presented while there is credit; both terms only move
  // in ways that keep a stalled beat stable until it is taken
  assign fifo_empty  = (count_q == CW'(0));
  assign credit_ok   = (outstanding_q < OW'(MAX_OUTSTANDING));
  assign tbl_valid_o = ~fifo_empty & credit_ok;
  assign tbl_data_o  = mem_q[rd_ptr_q];
  assign tbl_keep_o  = 1'b0;
  assign tbl_last_o  = 1'b0;
  assign issue       = tbl_valid_o & tbl_ready_i;

  // response register accepts whenever it is empty or being drained
  assign rsp_ready_o = ~reset & (~out_valid_q | out_ready_i);
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;

  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign outstanding_o = outstanding_q;
  assign nop_cnt_o     = nop_cnt_q;
  assign underflow_o   = underflow_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(FIFO_DEPTH));
  end

  // outstanding-request credit and unsolicited-response detection
  always_comb begin
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (rsp_hs && (outstanding_q == OW'(0))) begin
      underflow_d = 1'b1;
    end
    case ({issue, rsp_hs})
      2'b10: outstanding_d = outstanding_q + OW'(1);
      2'b01: begin
        if (outstanding_q != OW'(0)) begin
          outstanding_d = outstanding_q - OW'(1);
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // response register and saturating nop counter next-state
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    nop_cnt_d   = nop_cnt_q;
    if (rsp_hs) begin
      out_data_d  = rsp_data_i;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (nop_acc && (nop_cnt_q != 16'hFFFF)) begin
      nop_cnt_d = nop_cnt_q + 16'd1;
    end
  end

  // FIFO storage; cleared on reset so the idle data bus reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= cmd_data_i;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // credit, response and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      nop_cnt_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      nop_cnt_q     <= nop_cnt_d;
    end
  end

endmodule
